// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : 640x480@60 timing constants, frame-buffer geometry, pixel
//               flag bundle and the {y, x} address packing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_FP     = 10'd16;
    localparam logic [9:0] H_SYNC   = 10'd96;
    localparam logic [9:0] H_BP     = 10'd48;
    localparam logic [9:0] H_TOTAL  = 10'd800;

    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_FP     = 10'd10;
    localparam logic [9:0] V_SYNC   = 10'd2;
    localparam logic [9:0] V_BP     = 10'd33;
    localparam logic [9:0] V_TOTAL  = 10'd525;

    localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic [8:0] FB_W   = 9'd320;
    localparam logic [7:0] FB_H   = 8'd240;
    localparam int         ADDR_W = 17;

    // Sync flags are active-high here; polarity is applied at the outputs.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
    } vga_flags_t;

    function automatic logic [ADDR_W-1:0] pack_addr(input logic [7:0] y,
                                                    input logic [8:0] x);
        return {y, x};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : 800x525 horizontal/vertical counters with undelayed active and
//               sync flags and the 2x-replicated frame-buffer coordinate.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    output logic [8:0] x,
    output logic [7:0] y,
    output vga_flags_t flags
);

    logic [9:0] r_h;
    logic [9:0] r_v;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == H_TOTAL - 10'd1) begin
            r_h <= '0;
            r_v <= (r_v == V_TOTAL - 10'd1) ? 10'd0 : r_v + 10'd1;
        end else begin
            r_h <= r_h + 10'd1;
        end
    end

    assign x = r_h[9:1];
    assign y = r_v[8:1];

    assign flags.active = (r_h < H_ACTIVE) && (r_v < V_ACTIVE);
    assign flags.hsync  = (r_h >= H_SYNC_START) && (r_h < H_SYNC_END);
    assign flags.vsync  = (r_v >= V_SYNC_START) && (r_v < V_SYNC_END);

endmodule
`default_nettype wire

// File: rtl/vga_fb_stream_src.sv
`default_nettype none
// ============================================================================
// Module      : vga_fb_stream_src
// Description : VGA pixel-bus producer: reads the 320x240 frame buffer with
//               2x2 replication and aligns data, syncs and address (2 cycles).
//               Build macro VGA_TEST_PATTERN_EN replaces frame-buffer data with
//               eight colour bars.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_fb_stream_src
    import vga_timing_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              reset,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_rd_addr,
    input  logic [23:0]       fb_rd_data,
    output logic [23:0]       pixel_in,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              active_area,
    output logic              vsync,
    output logic              hsync_n,
    output logic              vsync_n
);

    logic [8:0]        w_x;
    logic [7:0]        w_y;
    vga_flags_t        w_flags;
    logic [23:0]       w_rd_data;
    logic [23:0]       w_pix;

    vga_flags_t        r_b_flags;
    logic [ADDR_W-1:0] r_b_addr;

    vga_timing_gen u_timing (
        .clk   (clk),
        .reset (reset),
        .x     (w_x),
        .y     (w_y),
        .flags (w_flags)
    );

    // Stage B: this register doubles as the RAM's address register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_b_flags <= '0;
            r_b_addr  <= '0;
        end else begin
            r_b_flags <= w_flags;
            r_b_addr  <= w_flags.active ? pack_addr(w_y, w_x) : '0;
        end
    end

    // Only single-cycle read latency is supported; others show black.
    generate
        if (RD_LATENCY == 1) begin : g_rd_lat_1
            assign w_rd_data = fb_rd_data;
        end else begin : g_rd_lat_unsupported
            assign w_rd_data = '0;
        end
    endgenerate

`ifdef VGA_TEST_PATTERN_EN
    function automatic logic [23:0] bar_color(input logic [8:0] x);
        logic [2:0] idx;
        idx = 3'(x / 9'd40);
        case (idx)
            3'd0:    return 24'hFFFFFF;
            3'd1:    return 24'hFFFF00;
            3'd2:    return 24'h00FFFF;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'hFF00FF;
            3'd5:    return 24'hFF0000;
            3'd6:    return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    assign fb_rd_en   = 1'b0;
    assign fb_rd_addr = '0;
    assign w_pix      = bar_color(r_b_addr[8:0]);
`else
    assign fb_rd_en   = r_b_flags.active;
    assign fb_rd_addr = r_b_addr;
    assign w_pix      = w_rd_data;
`endif

    // Stage C: capture read data with flags and address delayed to match.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_in    <= '0;
            pixel_addr  <= '0;
            active_area <= 1'b0;
            vsync       <= 1'b0;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
        end else begin
            pixel_in    <= r_b_flags.active ? w_pix : 24'd0;
            pixel_addr  <= r_b_addr;
            active_area <= r_b_flags.active;
            vsync       <= r_b_flags.vsync;
            hsync_n     <= ~r_b_flags.hsync;
            vsync_n     <= ~r_b_flags.vsync;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_stream_src.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_fb_stream_src
// Description : Directed self-checking bench for vga_fb_stream_src with a
//               frame buffer holding data = addr.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_fb_stream_src;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fb_rd_en;
    logic [16:0] fb_rd_addr;
    logic [23:0] fb_rd_data;
    logic [23:0] pixel_in;
    logic [16:0] pixel_addr;
    logic        active_area;
    logic        vsync;
    logic        hsync_n;
    logic        vsync_n;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic c_rd_en_on = 1'b0;
`else
    localparam logic c_rd_en_on = 1'b1;
`endif

    vga_fb_stream_src #(
        .RD_LATENCY (1),
        .ADDR_W     (17)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fb_rd_en    (fb_rd_en),
        .fb_rd_addr  (fb_rd_addr),
        .fb_rd_data  (fb_rd_data),
        .pixel_in    (pixel_in),
        .pixel_addr  (pixel_addr),
        .active_area (active_area),
        .vsync       (vsync),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n)
    );

    always #20 clk = ~clk;

    // Frame buffer contents equal their address; read data follows the
    // registered address within the same cycle.
    assign fb_rd_data = {7'd0, fb_rd_addr};

    function automatic logic [23:0] exp_pix(input logic [16:0] a);
`ifdef VGA_TEST_PATTERN_EN
        logic [8:0] x;
        x = a[8:0];
        if      (x < 9'd40)  return 24'hFFFFFF;
        else if (x < 9'd80)  return 24'hFFFF00;
        else if (x < 9'd120) return 24'h00FFFF;
        else if (x < 9'd160) return 24'h00FF00;
        else if (x < 9'd200) return 24'hFF00FF;
        else if (x < 9'd240) return 24'hFF0000;
        else if (x < 9'd280) return 24'h0000FF;
        else                 return 24'h000000;
`else
        return {7'd0, a};
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rd_en"},   32'(fb_rd_en),    32'd0);
        check({tag, "_rd_addr"}, 32'(fb_rd_addr),  32'd0);
        check({tag, "_pix"},     32'(pixel_in),    32'd0);
        check({tag, "_paddr"},   32'(pixel_addr),  32'd0);
        check({tag, "_active"},  32'(active_area), 32'd0);
        check({tag, "_vsync"},   32'(vsync),       32'd0);
        check({tag, "_hsync_n"}, 32'(hsync_n),     32'd1);
        check({tag, "_vsync_n"}, 32'(vsync_n),     32'd1);
    endtask

    int  act_cnt  = 0;
    int  hs_cnt   = 0;
    int  vs_cnt   = 0;
    int  vs_rise  = -1;
    logic vs_prev = 1'b0;

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("por");

        // Released at a falling edge: the rest of this cycle is cycle 0.
        reset = 1'b0;
        cyc   = 0;
        check("c0_rd_en", 32'(fb_rd_en), 32'd0);

        for (int k = 1; k <= 420002; k++) begin
            @(negedge clk);
            cyc = k;
            if (cyc >= 2 && cyc <= 420001) begin
                if (active_area) act_cnt++;
                if (!hsync_n)    hs_cnt++;
                if (vsync)       vs_cnt++;
                if (vsync && !vs_prev && vs_rise < 0) vs_rise = cyc;
                vs_prev = vsync;
            end
            case (cyc)
                1: begin
                    check("c1_rd_en",   32'(fb_rd_en),    32'(c_rd_en_on));
                    check("c1_rd_addr", 32'(fb_rd_addr),  32'd0);
                    check("c1_active",  32'(active_area), 32'd0);
                end
                2: begin
                    check("c2_active", 32'(active_area), 32'd1);
                    check("c2_paddr",  32'(pixel_addr),  32'd0);
                    check("c2_pix",    32'(pixel_in),    32'(exp_pix(17'd0)));
                end
                3:   check("c3_paddr", 32'(pixel_addr), 32'd0);
                4: begin
                    check("c4_paddr", 32'(pixel_addr), 32'd1);
                    check("c4_pix",   32'(pixel_in),   32'(exp_pix(17'd1)));
                end
                82:  check("h80_pix",  32'(pixel_in),   32'(exp_pix(17'd40)));
                640: check("h638_pix", 32'(pixel_in),   32'(exp_pix(17'h13F)));
                641: begin
                    check("c641_paddr",  32'(pixel_addr),  32'h13F);
                    check("c641_active", 32'(active_area), 32'd1);
                end
                642: begin
                    check("c642_active", 32'(active_area), 32'd0);
                    check("c642_paddr",  32'(pixel_addr),  32'd0);
                    check("c642_pix",    32'(pixel_in),    32'd0);
                end
                657: check("h655_hsync_n", 32'(hsync_n), 32'd1);
                658: check("h656_hsync_n", 32'(hsync_n), 32'd0);
                753: check("h751_hsync_n", 32'(hsync_n), 32'd0);
                754: check("h752_hsync_n", 32'(hsync_n), 32'd1);
                1612: check("v2_paddr",   32'(pixel_addr), 32'h205);
                2412: check("v3_paddr",   32'(pixel_addr), 32'h205);
                2413: check("v3_x5_paddr", 32'(pixel_addr), 32'h205);
                2414: check("v3_x6_paddr", 32'(pixel_addr), 32'h206);
                383841: begin
                    check("v479_paddr", 32'(pixel_addr), 32'h1DF3F);
                    check("v479_pix",   32'(pixel_in),   32'(exp_pix(17'h1DF3F)));
                end
                392001: check("v489_vsync", 32'(vsync), 32'd0);
                392002: begin
                    check("v490_vsync",   32'(vsync),   32'd1);
                    check("v490_vsync_n", 32'(vsync_n), 32'd0);
                end
                420001: begin
                    check("wrap_pre_active", 32'(active_area), 32'd0);
                    check("wrap_rd_en",      32'(fb_rd_en),    32'(c_rd_en_on));
                    check("wrap_rd_addr",    32'(fb_rd_addr),  32'd0);
                end
                420002: begin
                    check("wrap_active", 32'(active_area), 32'd1);
                    check("wrap_paddr",  32'(pixel_addr),  32'd0);
                end
                default: ;
            endcase
        end

        check("frame_active_cnt", 32'(act_cnt), 32'd307200);
        check("frame_hsync_cnt",  32'(hs_cnt),  32'd50400);
        check("frame_vsync_cnt",  32'(vs_cnt),  32'd1600);
        check("vsync_rise_cyc",   32'(vs_rise), 32'd392002);

        // Second frame: stop at counters (h=300, v=200).
        for (int k = 420003; k <= 580300; k++) begin
            @(negedge clk);
            cyc = k;
        end
        check("pre_rst_active", 32'(active_area), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        cyc++;
        check_reset_state("mid");
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            cyc++;
            check("mid_rst_vsync",  32'(vsync),       32'd0);
            check("mid_rst_active", 32'(active_area), 32'd0);
        end

        reset = 1'b0;
        cyc   = 0;
        check("rel_c0_vsync", 32'(vsync), 32'd0);
        @(negedge clk);
        cyc = 1;
        check("rel_c1_rd_en",  32'(fb_rd_en),    32'(c_rd_en_on));
        check("rel_c1_active", 32'(active_area), 32'd0);
        @(negedge clk);
        cyc = 2;
        check("rel_c2_active", 32'(active_area), 32'd1);
        check("rel_c2_paddr",  32'(pixel_addr),  32'd0);
        check("rel_c2_vsync",  32'(vsync),       32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
